// File: rtl/nbcac_pkg.sv
// ----------------------------------------------------------------------------
// nbcac_pkg
//   Shared constants and helpers for the NBCAC decode path.
//   - NBCAC_CODE_W : width of one NBCAC codeword (bits 5..1).
//   - NBCAC_DATA_W : width of the decoded data word.
//   - NBCAC_MAX_REQ: largest supported requester count.
//   - nbcac_lane_code(): extracts lane i from a packed codeword bus.
// ----------------------------------------------------------------------------
package nbcac_pkg;

  localparam int NBCAC_CODE_W  = 5;
  localparam int NBCAC_DATA_W  = 4;
  localparam int NBCAC_MAX_REQ = 8;

  // Lane i lives at [5*i+4 : 5*i]. Callers zero-extend their bus to the
  // maximum lane count so a single helper serves every NREQ.
  function automatic logic [NBCAC_CODE_W-1:0] nbcac_lane_code(
    input logic [NBCAC_CODE_W*NBCAC_MAX_REQ-1:0] codes,
    input int unsigned                           lane
  );
    return codes[lane*NBCAC_CODE_W +: NBCAC_CODE_W];
  endfunction

endpackage

// File: rtl/nbcac_4di_decoder_core.sv
// ----------------------------------------------------------------------------
// nbcac_4di_decoder_core
//   Combinational NBCAC codeword decoder. Codeword bits d[1]..d[5] carry the
//   Fibonacci weights 1, 2, 3, 5, 8; the data word is the weighted sum taken
//   modulo 16. Illegal codewords are not flagged, their sum is passed on.
//
// Ports
//   d  in  5  codeword, bit 1 at the LSB
//   v  out 4  decoded data word
// ----------------------------------------------------------------------------
module nbcac_4di_decoder_core
  import nbcac_pkg::*;
(
  input  logic [NBCAC_CODE_W:1]   d,
  output logic [NBCAC_DATA_W-1:0] v
);

  logic [4:0] sum;

  // Largest sum is 19, which needs 5 bits before the modulo-16 truncation.
  assign sum = {4'b0000, d[1]}
             + {3'b000, d[2], 1'b0}
             + (d[3] ? 5'd3 : 5'd0)
             + (d[4] ? 5'd5 : 5'd0)
             + {1'b0, d[5], 3'b000};

  assign v = sum[NBCAC_DATA_W-1:0];

endmodule

// File: rtl/nbcac_decode_arbiter.sv
// ----------------------------------------------------------------------------
// nbcac_decode_arbiter
//   Round-robin arbiter sharing one NBCAC decoder core among NREQ requesters.
//   The granted codeword passes a two-stage pipeline (S1 codeword register,
//   S2 output register) with the decoder between them. The output stream
//   carries the decoded word and the requester tag and honours backpressure.
//
//   Optional feature macro: NBCAC_ARB_STATS_EN adds per-requester saturating
//   delivery counters readable through stat_sel / stat_count.
//
// Ports
//   clock       in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   req_valid   in   NREQ     requester i presents a codeword
//   req_code    in   5*NREQ   lane i codeword at [5*i+4:5*i]
//   req_ready   out  NREQ     one-hot grant (combinational)
//   out_valid   out  1        out_data / out_tag hold a decoded word
//   out_ready   in   1        sink accepts the word
//   out_data    out  4        decoded data word
//   out_tag     out  TAG_W    requester that supplied the word
//   stat_sel    in   TAG_W    counter select   (NBCAC_ARB_STATS_EN only)
//   stat_count  out  CNT_W    selected counter (NBCAC_ARB_STATS_EN only)
// ----------------------------------------------------------------------------
module nbcac_decode_arbiter
  import nbcac_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int TAG_W = $clog2(NREQ),
  parameter int CNT_W = 16
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NBCAC_CODE_W*NREQ-1:0] req_code,
  output logic [NREQ-1:0]              req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NBCAC_DATA_W-1:0]      out_data,
  output logic [TAG_W-1:0]             out_tag
`ifdef NBCAC_ARB_STATS_EN
  ,
  input  logic [TAG_W-1:0]             stat_sel,
  output logic [CNT_W-1:0]             stat_count
`endif
);

  if (NREQ < 2 || NREQ > NBCAC_MAX_REQ || CNT_W < 1) begin : g_bad_cfg
    $error("nbcac_decode_arbiter: unsupported NREQ/CNT_W");
  end

  logic [NBCAC_CODE_W*NBCAC_MAX_REQ-1:0] code_ext;
  logic [TAG_W-1:0]                      last_grant;
  logic [TAG_W-1:0]                      grant_idx;
  logic                                  grant_found;
  logic [NBCAC_CODE_W-1:0]               grant_code;
  int                                    cand;

  logic                                  s1_valid;
  logic [NBCAC_CODE_W:1]                 s1_code;
  logic [TAG_W-1:0]                      s1_tag;
  logic [NBCAC_DATA_W-1:0]               dec_data;

  logic                                  s2_free;
  logic                                  s1_free;
  logic                                  take;

  always_comb begin
    code_ext                         = '0;
    code_ext[NBCAC_CODE_W*NREQ-1:0]  = req_code;
  end

  // Round-robin search: start one past the last granted index and wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last_grant) + off) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_W'(cand);
      end
    end
  end

  assign grant_code = nbcac_lane_code(code_ext, 32'(grant_idx));

  assign s2_free = ~out_valid | out_ready;
  assign s1_free = ~s1_valid | s2_free;

  // Gating with rst_n keeps the grant silent while the pipeline is held in reset.
  assign take      = s1_free & grant_found & rst_n;
  assign req_ready = take ? (NREQ'(1) << grant_idx) : '0;

  // ---- S1: granted codeword register ----
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      last_grant <= TAG_W'(NREQ - 1);
    end else begin
      if (s1_free) begin
        s1_valid <= take;
      end
      if (take) begin
        last_grant <= grant_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (take) begin
      s1_code <= grant_code;
      s1_tag  <= grant_idx;
    end
  end

  nbcac_4di_decoder_core u_dec (
    .v (dec_data),
    .d (s1_code)
  );

  // ---- S2: output register ----
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= dec_data;
        out_tag  <= s1_tag;
      end
    end
  end

`ifdef NBCAC_ARB_STATS_EN
  logic [CNT_W-1:0] stat_cnt [NREQ];

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        stat_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (out_valid && out_ready && (out_tag == TAG_W'(i)) && (stat_cnt[i] != '1)) begin
          stat_cnt[i] <= stat_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stat_sel == TAG_W'(i)) begin
        stat_count = stat_cnt[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_nbcac_decode_arbiter.sv
// ----------------------------------------------------------------------------
// tb_nbcac_decode_arbiter
//   Self-checking bench: a queue-based reference model is compared against the
//   DUT on every falling edge, and directed phases pin literal expectations.
//   Build with +define+NBCAC_ARB_STATS_EN to include the counter phase.
// ----------------------------------------------------------------------------
module tb_nbcac_decode_arbiter;

  localparam int NREQ  = 4;
  localparam int TAG_W = $clog2(NREQ);
  localparam int CNT_W = 4;

  logic                clock = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [5*NREQ-1:0]   req_code;
  logic [NREQ-1:0]     req_ready;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_data;
  logic [TAG_W-1:0]    out_tag;
`ifdef NBCAC_ARB_STATS_EN
  logic [TAG_W-1:0]    stat_sel;
  logic [CNT_W-1:0]    stat_count;
`endif

  nbcac_decode_arbiter #(
    .NREQ  (NREQ),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_code   (req_code),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag)
`ifdef NBCAC_ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fibonacci-weighted sum of the codeword, modulo 16.
  function automatic int model_decode(input logic [4:0] c);
    int w [5] = '{1, 2, 3, 5, 8};
    int s = 0;
    for (int k = 0; k < 5; k++) begin
      if (c[k]) s += w[k];
    end
    return s % 16;
  endfunction

  // ---------------- reference model ----------------
  // Words in flight, oldest first. 'old' means the word has already crossed
  // one edge after being granted, so it may be presented on the output.
  typedef struct {
    int data;
    int tag;
    bit old;
  } ent_t;

  ent_t sbq[$];
  int   mlast = NREQ - 1;

  always @(negedge clock) begin
    bit   exp_ov;
    bit   s1_busy;
    bit   can_take;
    int   pick;
    int   exp_rdy;
    ent_t e;
    if (!rst_n) begin
      sbq.delete();
      mlast = NREQ - 1;
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
    end else begin
      exp_ov   = (sbq.size() > 0) && sbq[0].old;
      // Room exists unless two words are held, or one fresh word waits
      // behind an output that cannot drain.
      s1_busy  = (sbq.size() == 2) || (sbq.size() == 1 && !sbq[0].old);
      can_take = !s1_busy || !exp_ov || out_ready;
      pick = -1;
      for (int off = 1; off <= NREQ; off++) begin
        int c;
        c = (mlast + off) % NREQ;
        if (pick < 0 && req_valid[c]) pick = c;
      end
      exp_rdy = (can_take && pick >= 0) ? (1 << pick) : 0;

      chk("req_ready", int'(req_ready), exp_rdy);
      chk("out_valid", int'(out_valid), int'(exp_ov));
      if (exp_ov && out_valid) begin
        chk("out_data", int'(out_data), sbq[0].data);
        chk("out_tag", int'(out_tag), sbq[0].tag);
      end

      if (exp_ov && out_ready) void'(sbq.pop_front());
      foreach (sbq[k]) sbq[k].old = 1'b1;
      if (exp_rdy != 0) begin
        e.data = model_decode(req_code[5*pick +: 5]);
        e.tag  = pick;
        e.old  = 1'b0;
        sbq.push_back(e);
        mlast = pick;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [4:0] c);
    req_code[5*lane +: 5] = c;
  endtask

  task automatic rand_codes();
    for (int i = 0; i < NREQ; i++) set_lane(i, 5'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int d0;
    int t0;
    int sent;
    int cyc;
    bit fired;
    logic [4:0] nxt;

    rst_n     = 1'b0;
    req_valid = '0;
    req_code  = '0;
    out_ready = 1'b1;
`ifdef NBCAC_ARB_STATS_EN
    stat_sel  = '0;
`endif

    // Reset state, with all requesters asking to prove the grant is gated.
    tick();
    req_valid = '1;
    #1;
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_tag", int'(out_tag), 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;

    // Single requester 2: A=01010 decodes to 7, B=10001 decodes to 9.
    set_lane(2, 5'b01010);
    req_valid = 4'b0100;
    tick();
    chk("single_lat_e0", int'(out_valid), 0);
    set_lane(2, 5'b10001);
    tick();
    req_valid = '0;
    chk("single_a_valid", int'(out_valid), 1);
    chk("single_a_data", int'(out_data), 7);
    chk("single_a_tag", int'(out_tag), 2);
    tick();
    chk("single_b_valid", int'(out_valid), 1);
    chk("single_b_data", int'(out_data), 9);
    chk("single_b_tag", int'(out_tag), 2);
    tick();
    chk("single_idle", int'(out_valid), 0);

    // Fairness from a fresh reset.
    do_reset();
    req_valid = '1;
    rand_codes();
    tick();
    chk("fair_first_empty", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) begin
      rand_codes();
      tick();
      chk("fair_valid", int'(out_valid), 1);
      chk("fair_tag", int'(out_tag), i % NREQ);
    end

    // Backpressure with both stages full.
    out_ready = 1'b0;
    #1;
    chk("bp_ready_same_cycle", int'(req_ready), 0);
    d0 = int'(out_data);
    t0 = int'(out_tag);
    for (int i = 0; i < 5; i++) begin
      rand_codes();
      tick();
      chk("bp_ready", int'(req_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data_stable", int'(out_data), d0);
      chk("bp_tag_stable", int'(out_tag), t0);
    end
    req_valid = '0;
    out_ready = 1'b1;
    #1;
    chk("bp_rel_tag0", int'(out_tag), 3);
    tick();
    chk("bp_rel_valid1", int'(out_valid), 1);
    chk("bp_rel_tag1", int'(out_tag), 0);
    tick();
    chk("bp_rel_empty", int'(out_valid), 0);

    // Reset while both stages hold words.
    req_valid = '1;
    out_ready = 1'b0;
    rand_codes();
    tick();
    tick();
    chk("mid_full", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_req_ready", int'(req_ready), 0);
    tick();
    tick();
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("mid_first_grant", int'(req_ready), 1);
    req_valid = '0;
    tick();
    tick();
    tick();

    // All 32 codewords through requester 1 under random backpressure.
    sent = 0;
    cyc  = 0;
    set_lane(1, 5'd0);
    req_valid = 4'b0010;
    while (sent < 32 && cyc < 2000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      fired = req_ready[1];
      tick();
      cyc++;
      if (fired) begin
        sent++;
        nxt = 5'(sent);
        set_lane(1, nxt);
        if (sent == 32) req_valid = '0;
      end
    end
    req_valid = '0;
    chk("exh_sent", sent, 32);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("exh_drained", sbq.size(), 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      req_valid = NREQ'($urandom);
      rand_codes();
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("rand_drained", sbq.size(), 0);

`ifdef NBCAC_ARB_STATS_EN
    // Requester 3 delivers 20 words; a 4-bit counter saturates at 15.
    do_reset();
    req_valid = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      set_lane(3, 5'($urandom));
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    tick();
    for (int i = 0; i < NREQ; i++) begin
      stat_sel = TAG_W'(i);
      #1;
      chk("stat_count", int'(stat_count), (i == 3) ? 15 : 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
